// File: rtl/grid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : grid_pkg
//  Brief    : Shared grid dimensions, coordinate widths and scanner states
//  Revision : 1.0 - initial release
// ============================================================================
package grid_pkg;

    // Default simulation grid dimensions in cells
    localparam int HPIXELS_DEF = 320;
    localparam int VPIXELS_DEF = 180;

    // Coordinate widths expected by the grid-to-BRAM address calculator
    localparam int HOR_SIZE  = $clog2(HPIXELS_DEF);
    localparam int VERT_SIZE = $clog2(VPIXELS_DEF);

    // Scanner states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

endpackage : grid_pkg
`default_nettype wire

// File: rtl/grid_scanner_bounded_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bounded_counter
//  Brief    : Unsigned counter with load, increment and wrap-to-min at max.
//             at_max is exposed so several instances can be chained.
//  Revision : 1.0 - initial release
// ============================================================================
module bounded_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_min,
    input  logic [WIDTH-1:0] i_max,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_at_max
);

    logic [WIDTH-1:0] r_count;

    assign o_at_max = (r_count == i_max);
    assign o_count  = r_count;

    // Load has priority; an increment at the upper bound wraps back to min
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            r_count <= o_at_max ? i_min : (r_count + WIDTH'(1));
        end
    end

endmodule : bounded_counter
`default_nettype wire

// File: rtl/grid_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : grid_scanner
//  Brief    : Row-major (hor, vert) coordinate generator with valid/ready
//             handshake, multi-pass sweeps, optional border exclusion and
//             per-beat boundary/framing flags.
//  Revision : 1.0 - initial release
// ============================================================================
module grid_scanner
    import grid_pkg::*;
#(
    parameter int HPIXELS = HPIXELS_DEF,
    parameter int VPIXELS = VPIXELS_DEF,
    parameter int PASS_W  = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       start_in,
    input  logic [PASS_W-1:0]          num_passes_in,
    input  logic                       skip_border_in,
    input  logic                       ready_in,
    output logic                       valid_out,
    output logic [$clog2(HPIXELS)-1:0] hor_out,
    output logic [$clog2(VPIXELS)-1:0] vert_out,
    output logic [3:0]                 edge_out,
    output logic                       first_out,
    output logic                       last_out,
    output logic                       final_out,
    output logic [PASS_W-1:0]          pass_out,
    output logic                       busy_out,
    output logic                       done_out
);

    localparam int XW = $clog2(HPIXELS);
    localparam int YW = $clog2(VPIXELS);

    localparam logic [1:0] C_IDLE = IDLE;
    localparam logic [1:0] C_SCAN = SCAN;
    localparam logic [1:0] C_DONE = DONE;

    logic [1:0]        r_state;
    logic [PASS_W-1:0] r_num_passes;
    logic              r_skip;

    logic              w_start_ok;
    logic              w_scan;
    logic              w_adv;
    logic              w_sweep_end;
    logic [XW-1:0]     w_xmin, w_xmax, w_xload;
    logic [YW-1:0]     w_ymin, w_ymax, w_yload;
    logic [PASS_W-1:0] w_pass_max;
    logic [XW-1:0]     w_x;
    logic [YW-1:0]     w_y;
    logic [PASS_W-1:0] w_pass;
    logic              w_x_at_max, w_y_at_max, w_p_at_max;

    assign w_start_ok  = start_in && (r_state == C_IDLE);
    assign w_scan      = (r_state == C_SCAN);
    assign w_adv       = w_scan && ready_in;
    assign w_sweep_end = w_adv && w_x_at_max && w_y_at_max && w_p_at_max;

    // Scan bounds follow the latched border mode; the load values use the
    // live input because the counters load in the same cycle it is latched.
    assign w_xmin     = r_skip ? XW'(1) : '0;
    assign w_xmax     = r_skip ? XW'(HPIXELS - 2) : XW'(HPIXELS - 1);
    assign w_ymin     = r_skip ? YW'(1) : '0;
    assign w_ymax     = r_skip ? YW'(VPIXELS - 2) : YW'(VPIXELS - 1);
    assign w_xload    = skip_border_in ? XW'(1) : '0;
    assign w_yload    = skip_border_in ? YW'(1) : '0;
    assign w_pass_max = r_num_passes - PASS_W'(1);

    bounded_counter #(.WIDTH(XW)) u_x_cnt (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .i_load     (w_start_ok),
        .i_load_val (w_xload),
        .i_min      (w_xmin),
        .i_max      (w_xmax),
        .i_inc      (w_adv),
        .o_count    (w_x),
        .o_at_max   (w_x_at_max)
    );

    bounded_counter #(.WIDTH(YW)) u_y_cnt (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .i_load     (w_start_ok),
        .i_load_val (w_yload),
        .i_min      (w_ymin),
        .i_max      (w_ymax),
        .i_inc      (w_adv && w_x_at_max),
        .o_count    (w_y),
        .o_at_max   (w_y_at_max)
    );

    // The pass index never wraps: the last pass ends the sweep instead
    bounded_counter #(.WIDTH(PASS_W)) u_pass_cnt (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .i_load     (w_start_ok),
        .i_load_val ('0),
        .i_min      ('0),
        .i_max      (w_pass_max),
        .i_inc      (w_adv && w_x_at_max && w_y_at_max && !w_p_at_max),
        .o_count    (w_pass),
        .o_at_max   (w_p_at_max)
    );

    // Sweep control: latch parameters on an accepted start, step through states
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= C_IDLE;
            r_num_passes <= '0;
            r_skip       <= 1'b0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (start_in) begin
                        r_num_passes <= num_passes_in;
                        r_skip       <= skip_border_in;
                        r_state      <= (num_passes_in != '0) ? C_SCAN : C_DONE;
                    end
                end
                C_SCAN: begin
                    if (w_sweep_end) begin
                        r_state <= C_DONE;
                    end
                end
                C_DONE: begin
                    r_state <= C_IDLE;
                end
                default: begin
                    r_state <= C_IDLE;
                end
            endcase
        end
    end

    assign valid_out = w_scan;
    assign busy_out  = (r_state != C_IDLE);
    assign done_out  = (r_state == C_DONE);
    assign hor_out   = w_x;
    assign vert_out  = w_y;
    assign pass_out  = w_pass;

    // Flags only qualify a valid beat; edge reflects the true grid border
    assign first_out = w_scan && (w_x == w_xmin) && (w_y == w_ymin);
    assign last_out  = w_scan && w_x_at_max && w_y_at_max;
    assign final_out = last_out && w_p_at_max;
    assign edge_out  = (w_scan && !r_skip) ?
                       {(w_x == '0), (w_x == XW'(HPIXELS - 1)),
                        (w_y == '0), (w_y == YW'(VPIXELS - 1))} : 4'b0000;

endmodule : grid_scanner
`default_nettype wire

// File: tb/tb_grid_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grid_scanner
//  Brief    : Self-checking bench for grid_scanner on a 4x3 grid against a
//             queue of expected beats built from the sweep rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_grid_scanner;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int PW = 4;
    localparam int HW = $clog2(H);
    localparam int VW = $clog2(V);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] num = '0;
    logic          skip = 1'b0;
    logic          ready = 1'b0;
    logic          valid, first, last, fin, busy, done;
    logic [HW-1:0] hor;
    logic [VW-1:0] vert;
    logic [3:0]    edge_o;
    logic [PW-1:0] pass;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int       x;
        int       y;
        int       p;
        bit       f;
        bit       l;
        bit       fi;
        bit [3:0] e;
    } beat_t;

    beat_t q[$];

    grid_scanner #(.HPIXELS(H), .VPIXELS(V), .PASS_W(PW)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .start_in       (start),
        .num_passes_in  (num),
        .skip_border_in (skip),
        .ready_in       (ready),
        .valid_out      (valid),
        .hor_out        (hor),
        .vert_out       (vert),
        .edge_out       (edge_o),
        .first_out      (first),
        .last_out       (last),
        .final_out      (fin),
        .pass_out       (pass),
        .busy_out       (busy),
        .done_out       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pk(input logic v, input logic [HW-1:0] h, input logic [VW-1:0] y,
                                       input logic [3:0] e, input logic f, input logic l, input logic fi,
                                       input logic [PW-1:0] p, input logic b, input logic d);
        return {14'b0, v, h, y, e, f, l, fi, p, b, d};
    endfunction

    function automatic logic [31:0] obs_all();
        return pk(valid, hor, vert, edge_o, first, last, fin, pass, busy, done);
    endfunction

    // Reference: enumerate every beat of the sweep directly from the rules
    task automatic build(input int n, input bit sk);
        int xmin, xmax, ymin, ymax;
        beat_t b;
        q.delete();
        xmin = sk ? 1 : 0;
        ymin = sk ? 1 : 0;
        xmax = sk ? H - 2 : H - 1;
        ymax = sk ? V - 2 : V - 1;
        for (int p = 0; p < n; p++)
            for (int y = ymin; y <= ymax; y++)
                for (int x = xmin; x <= xmax; x++) begin
                    b.x  = x;
                    b.y  = y;
                    b.p  = p;
                    b.f  = (x == xmin) && (y == ymin);
                    b.l  = (x == xmax) && (y == ymax);
                    b.fi = b.l && (p == n - 1);
                    b.e  = sk ? 4'b0000 : {x == 0, x == H - 1, y == 0, y == V - 1};
                    q.push_back(b);
                end
    endtask

    // rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random. noise: random start pulses.
    task automatic run_sweep(input int n, input bit sk, input int rmode, input bit noise, input bit abort);
        int cyc;
        bit [3:0] pat;
        pat = 4'b1001;
        build(n, sk);
        @(negedge clk);
        start = 1'b1; num = PW'(n); skip = sk; ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (q.size() > 0 && cyc < 1000) begin
            chk("beat", obs_all(),
                pk(1'b1, HW'(q[0].x), VW'(q[0].y), q[0].e, q[0].f, q[0].l, q[0].fi, PW'(q[0].p), 1'b1, 1'b0));
            if (abort && q[0].x == 2 && q[0].y == 1) begin
                #2 rst_n = 1'b0;
                #1 chk("async_reset", obs_all(), 32'h0);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("reset_hold", obs_all(), 32'h0);
                end
                rst_n = 1'b1;
                q.delete();
                return;
            end
            case (rmode)
                0:       ready = 1'b1;
                1:       ready = pat[3 - (cyc % 4)];
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                num   = PW'($urandom_range(0, 15));
                skip  = 1'($urandom_range(0, 1));
            end
            if (ready) void'(q.pop_front());
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (q.size() != 0) chk("timeout", 32'(q.size()), 32'h0);
        chk("done_cycle", {29'b0, valid, busy, done}, 32'b011);
        if (noise) begin
            start = 1'b1; num = 4'd2;
        end
        @(negedge clk);
        start = 1'b0;
        chk("idle_after", {29'b0, valid, busy, done}, 32'b000);
    endtask

    initial begin
        #12;
        chk("reset_state", obs_all(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(1, 1'b0, 0, 1'b0, 1'b0);
        run_sweep(2, 1'b1, 0, 1'b0, 1'b0);
        run_sweep(1, 1'b0, 1, 1'b0, 1'b0);
        run_sweep(0, 1'b0, 0, 1'b0, 1'b0);
        run_sweep(2, 1'b0, 2, 1'b1, 1'b0);
        run_sweep(3, 1'b1, 1, 1'b1, 1'b0);
        run_sweep(1, 1'b0, 0, 1'b0, 1'b1);
        run_sweep(1, 1'b0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++)
            run_sweep($urandom_range(0, 3), 1'($urandom_range(0, 1)), 2,
                      1'($urandom_range(0, 1)), 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_grid_scanner
`default_nettype wire
